// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and single-cycle bubble insertion.
// Optional IDEX_STALL_CNT_EN adds a saturating 16-bit count of inserted load-use bubbles.
module idex_hazard_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic        ex_valid,
  output logic        stall_o
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t     state, state_nxt;
  logic [6:0] id_op;
  logic [4:0] ex_rd;
  logic       load_in_ex;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;

  always_comb begin
    id_op      = id_instr[6:0];
    ex_rd      = ex_instr[11:7];
    load_in_ex = ex_valid && (ex_instr[6:0] == 7'b0000011) && (ex_rd != 5'd0);
    rs1_used   = !((id_op == 7'b0110111) || (id_op == 7'b0010111) || (id_op == 7'b1101111));
    rs2_used   = (id_op == 7'b0110011) || (id_op == 7'b0100011) || (id_op == 7'b1100011);
    hazard     = load_in_ex &&
                 ((rs1_used && (id_instr[19:15] == ex_rd)) ||
                  (rs2_used && (id_instr[24:20] == ex_rd)));
  end

  // Hold and flush both suppress the stall: hold already freezes the front end,
  // and a flushed ID instruction is dead so there is nothing to protect.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    unique case (state)
      RUN: begin
        if (!hold_i && !flush_i && hazard) begin
          state_nxt = BUBBLE;
          stall_o   = 1'b1;
        end
      end
      BUBBLE: begin
        if (!hold_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_instr    <= NOP_INSTR;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_valid    <= 1'b0;
    end else if (hold_i) begin
      ex_instr    <= ex_instr;
      ex_pc       <= ex_pc;
      ex_rs1_data <= ex_rs1_data;
      ex_rs2_data <= ex_rs2_data;
      ex_imm      <= ex_imm;
      ex_valid    <= ex_valid;
    end else if (flush_i || stall_o) begin
      ex_instr    <= NOP_INSTR;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_valid    <= 1'b0;
    end else begin
      ex_instr    <= id_instr;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_valid    <= 1'b1;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares. Define IDEX_STALL_CNT_EN to also check stall_cnt.
module tb_idex_hazard_stage;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD   = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] LUI   = 32'h00028337; // lui  x6,0x28
  localparam logic [31:0] LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADDI6 = 32'h00100313; // addi x6,x0,1
  localparam logic [31:0] ADDI7 = 32'h00200393; // addi x7,x0,2
  localparam logic [31:0] SW    = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] ADD8  = 32'h00A48433; // add  x8,x9,x10

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic        hold_i, flush_i;
  logic [31:0] ex_instr, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_valid, stall_o;
`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  idex_hazard_stage #(.NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rstn(rstn),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .hold_i(hold_i), .flush_i(flush_i),
    .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_valid(ex_valid), .stall_o(stall_o)
`ifdef IDEX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic        valid, stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_cnt = '0;
  bit          stim_done = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every negedge with a pending expectation is one observed cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "ex_instr", ex_instr, e.instr);
        chk(e.nm, "ex_pc", ex_pc, e.pc);
        chk(e.nm, "ex_rs1", ex_rs1_data, e.rs1);
        chk(e.nm, "ex_rs2", ex_rs2_data, e.rs2);
        chk(e.nm, "ex_imm", ex_imm, e.imm);
        chk(e.nm, "ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk(e.nm, "stall", {31'd0, stall_o}, {31'd0, e.stall});
`ifdef IDEX_STALL_CNT_EN
        chk(e.nm, "stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
`endif
      end
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic hold, input logic flush);
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = pc + 32'h1000_0001;
    id_rs2_data = pc + 32'h2000_0002;
    id_imm      = pc + 32'h3000_0003;
    hold_i      = hold;
    flush_i     = flush;
  endtask

  task automatic push(input string nm, input logic [31:0] e_instr, input logic [31:0] e_pc,
                      input logic e_valid, input logic e_stall);
    exp_t e;
    e.nm    = nm;
    e.instr = e_instr;
    e.valid = e_valid;
    e.stall = e_stall;
    e.pc    = e_valid ? e_pc : 32'd0;
    e.rs1   = e_valid ? e_pc + 32'h1000_0001 : 32'd0;
    e.rs2   = e_valid ? e_pc + 32'h2000_0002 : 32'd0;
    e.imm   = e_valid ? e_pc + 32'h3000_0003 : 32'd0;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  // One cycle: drive ID inputs, expect EX outputs from the previous edge and stall for these inputs.
  task automatic cyc(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                     input logic hold, input logic flush,
                     input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic e_valid, input logic e_stall);
    @(posedge clk);
    #1;
    drive(instr, pc, hold, flush);
    push(nm, e_instr, e_pc, e_valid, e_stall);
    if (e_stall) exp_cnt++;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from both clock edges' sampling.
  task automatic rst_cyc(input string nm, input logic [31:0] instr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    drive(instr, pc, 1'b0, 1'b0);
    exp_cnt = '0;
    push(nm, NOP, 32'd0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #4 rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    drive(ADDI7, 32'h0FC, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push("reset", NOP, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;

    cyc("c1_first",   LW,    32'h100, 0, 0, ADDI7, 32'h0FC, 1, 0);
    cyc("rs1_stall",  ADD,   32'h104, 0, 0, LW,    32'h100, 1, 1);
    cyc("rs1_bubble", ADD,   32'h104, 0, 0, NOP,   32'h0,   0, 0);
    cyc("rs1_issue",  ADDI7, 32'h108, 0, 0, ADD,   32'h104, 1, 0);
    cyc("pre_lui",    LW,    32'h10C, 0, 0, ADDI7, 32'h108, 1, 0);
    cyc("lui_filter", LUI,   32'h110, 0, 0, LW,    32'h10C, 1, 0);
    cyc("pre_x0",     LW0,   32'h114, 0, 0, LUI,   32'h110, 1, 0);
    cyc("x0_filter",  ADDI6, 32'h118, 0, 0, LW0,   32'h114, 1, 0);
    cyc("pre_sw",     LW,    32'h11C, 0, 0, ADDI6, 32'h118, 1, 0);
    cyc("rs2_stall",  SW,    32'h120, 0, 0, LW,    32'h11C, 1, 1);
    cyc("rs2_bubble", SW,    32'h120, 0, 0, NOP,   32'h0,   0, 0);
    cyc("rs2_issue",  LW,    32'h124, 0, 0, SW,    32'h120, 1, 0);
    cyc("flush_haz",  ADD,   32'h128, 0, 1, LW,    32'h124, 1, 0);
    cyc("flush_nop",  ADD8,  32'h12C, 0, 0, NOP,   32'h0,   0, 0);
    cyc("flush_next", LW,    32'h130, 0, 0, ADD8,  32'h12C, 1, 0);
    cyc("hold1",      ADD,   32'h134, 1, 0, LW,    32'h130, 1, 0);
    cyc("hold2",      ADD,   32'h134, 1, 0, LW,    32'h130, 1, 0);
    cyc("hold3",      ADD,   32'h134, 1, 0, LW,    32'h130, 1, 0);
    cyc("hold_rel",   ADD,   32'h134, 0, 0, LW,    32'h130, 1, 1);
    cyc("hold_bub",   ADD,   32'h134, 0, 0, NOP,   32'h0,   0, 0);
    cyc("hold_issue", ADDI7, 32'h138, 0, 0, ADD,   32'h134, 1, 0);
    cyc("pre_bhold",  LW,    32'h13C, 0, 0, ADDI7, 32'h138, 1, 0);
    cyc("bh_stall",   ADD,   32'h140, 0, 0, LW,    32'h13C, 1, 1);
    cyc("bh_hold",    ADD,   32'h140, 1, 0, NOP,   32'h0,   0, 0);
    cyc("bh_release", ADD,   32'h140, 0, 0, NOP,   32'h0,   0, 0);
    cyc("bh_issue",   ADDI7, 32'h144, 0, 0, ADD,   32'h140, 1, 0);
    cyc("pre_rstbub", LW,    32'h148, 0, 0, ADDI7, 32'h144, 1, 0);
    cyc("rb_stall",   ADD,   32'h14C, 0, 0, LW,    32'h148, 1, 1);
    rst_cyc("mid_reset", ADD, 32'h14C);
    cyc("post_reset", ADDI7, 32'h150, 0, 0, ADD,   32'h14C, 1, 0);
    cyc("p1_load",    LW,    32'h154, 0, 0, ADDI7, 32'h150, 1, 0);
    cyc("p1_stall",   ADD,   32'h158, 0, 0, LW,    32'h154, 1, 1);
    cyc("p1_bubble",  ADD,   32'h158, 0, 0, NOP,   32'h0,   0, 0);
    cyc("p2_load",    LW,    32'h15C, 0, 0, ADD,   32'h158, 1, 0);
    cyc("p2_stall",   SW,    32'h160, 0, 0, LW,    32'h15C, 1, 1);
    cyc("p2_bubble",  SW,    32'h160, 0, 0, NOP,   32'h0,   0, 0);
    cyc("pf_load",    LW,    32'h164, 0, 0, SW,    32'h160, 1, 0);
    cyc("pf_flush",   ADD,   32'h168, 0, 1, LW,    32'h164, 1, 0);
    cyc("p3_load",    LW,    32'h16C, 0, 0, NOP,   32'h0,   0, 0);
    cyc("p3_hold",    ADD,   32'h170, 1, 0, LW,    32'h16C, 1, 0);
    cyc("p3_stall",   ADD,   32'h170, 0, 0, LW,    32'h16C, 1, 1);
    cyc("p3_bubble",  ADD,   32'h170, 0, 0, NOP,   32'h0,   0, 0);
    cyc("p4_load",    LW,    32'h174, 0, 0, ADD,   32'h170, 1, 0);
    cyc("p4_stall",   ADD,   32'h178, 0, 0, LW,    32'h174, 1, 1);
    cyc("p4_bubble",  ADD,   32'h178, 0, 0, NOP,   32'h0,   0, 0);
    cyc("final",      ADDI7, 32'h17C, 0, 0, ADD,   32'h178, 1, 0);

    repeat (3) @(negedge clk);
    stim_done = 1'b1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idex_hazard_stage.md
# idex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage RV32I core. It captures decoded operands from ID and presents the EX-stage instruction to the ALU operand muxes and the EX-side forwarding logic. On a load-use dependency it inserts a single-cycle bubble and freezes PC and IF/ID. It also honours branch flushes and global memory holds.

## Interface

Parameters:
- `NOP_INSTR`, default 32'h00000013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: core clock; all registers update on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `id_instr` in 32: instruction in ID.
- `id_pc` in 32: PC of ID instruction.
- `id_rs1_data` in 32: register-file read of rs1.
- `id_rs2_data` in 32: register-file read of rs2.
- `id_imm` in 32: sign-extended immediate.
- `hold_i` in 1: global freeze from the memory subsystem.
- `flush_i` in 1: branch/jump mispredict resolved in EX; kill ID.
- `ex_instr` out 32: registered EX instruction; feeds the forwarding unit.
- `ex_pc` out 32: registered PC.
- `ex_rs1_data` out 32: registered rs1 operand.
- `ex_rs2_data` out 32: registered rs2 operand.
- `ex_imm` out 32: registered immediate.
- `ex_valid` out 1: EX slot holds a real instruction.
- `stall_o` out 1: combinational; freeze PC and IF/ID this cycle.

## Operation

- **Load detect.** EX holds a load when `ex_valid` is set, `ex_instr[6:0]` is 7'b0000011, and `ex_instr[11:7]` is not 0.
- **rs1 use.** `id_instr` uses rs1 unless its opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
- **rs2 use.** `id_instr` uses rs2 only for R (0110011), S (0100011) and B (1100011) opcodes.
- **Hazard.** Hazard = load detect AND ((rs1 used AND `id_instr[19:15]` equals `ex_instr[11:7]`) OR (rs2 used AND `id_instr[24:20]` equals `ex_instr[11:7]`)).
- **FSM.** Two states, RUN and BUBBLE.
  - RUN to BUBBLE: hazard is true and neither `hold_i` nor `flush_i` is asserted.
  - BUBBLE to RUN: unconditional on the next non-held edge.
  - A BUBBLE cycle never raises a second hazard, because the bubble is not a load.
- **Update priority per edge** (highest first):
  - `hold_i`: all registers and the state keep their values; `stall_o` is forced to 0, since hold already freezes the front end.
  - `flush_i`: load the bubble (`ex_instr` = `NOP_INSTR`, `ex_valid` = 0, data outputs = 0); state goes to RUN.
  - hazard: load the bubble; `stall_o` = 1 for this cycle.
  - otherwise: capture all `id_*` inputs and set `ex_valid` = 1.
- **Simultaneous hazard and flush.** Flush wins and `stall_o` = 0, because the ID instruction is dead.
- **Reset.** Asynchronous assertion of `rstn` low gives:
  - `ex_instr` = `NOP_INSTR`;
  - `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm` = 0;
  - `ex_valid` = 0;
  - state = RUN.
- **Reset mid-bubble.** Reset returns to RUN with no pending stall.
- **Data outputs.** No arithmetic; all fields are passed through at full 32-bit width.

## Timing

- Latency is one cycle from the `id_*` inputs to the `ex_*` outputs.
- `stall_o` is combinational from `id_instr`, `ex_instr`, `ex_valid`, `hold_i` and `flush_i`. It is valid in the same cycle and must settle before the PC and IF/ID enables.
- A load-use stall costs exactly one cycle. On the following edge the dependent instruction enters EX, and the load is in MEM for forwarding.
- `ex_instr` changes only on clock edges. The downstream forwarding unit samples it combinationally.

## Configuration

- `IDEX_STALL_CNT_EN` defined:
  - adds output `stall_cnt` (16 bits);
  - the counter increments on every edge that inserts a load-use bubble (not flush, not hold);
  - it saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan

- **Reset.** Assert `rstn`=0 mid-cycle, asynchronously. Required: `ex_instr`=32'h00000013, `ex_valid`=0, all data outputs 0, `stall_o`=0.
- **Load-use on rs1.** EX holds `lw x5,0(x1)` (32'h0000A283), ID holds `add x6,x5,x7` (32'h00728333).
  - Same cycle: `stall_o`=1.
  - Next edge: `ex_instr`=NOP, `ex_valid`=0.
  - Edge after: `ex_instr`=32'h00728333 and `stall_o`=0.
- **False-match filters.**
  - ID `lui x6,0x28` (32'h00028337) behind the lw: rs1 field is 5 but unused, so `stall_o`=0.
  - EX `lw x0,0(x1)` (32'h0000A003) with ID `addi x6,x0,1`: `stall_o`=0.
- **Flush beats hazard.** Load-use pair as above with `flush_i`=1. Required: `stall_o`=0, the next `ex_instr` is NOP, and the following cycle is normal capture.
- **Hold.** `hold_i`=1 for 3 cycles during the load-use pair. Required: all outputs are unchanged and `stall_o`=0. After release the stall occurs exactly once.
- **Counter** (with `IDEX_STALL_CNT_EN` defined). Required: 4 load-use pairs give `stall_cnt`=4; flushes and holds do not increment it.
